// File: rtl/cache_line_mp.sv
// rtl/cache_line_mp.sv - multi-port cache line with per-word dirty tracking; optional macro CACHE_LINE_STATS_EN adds hit/miss counters
module cache_line_mp #(
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32,
    parameter int LSBBITS  = 7,
    parameter int NRDPORTS = 2,
    parameter int TTLBITS  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NRDPORTS*ADDRBITS-1:0]  rd_addr,
    input  logic [NRDPORTS-1:0]           rd_req,
    output logic [NRDPORTS-1:0]           rd_valid,
    output logic [NRDPORTS*DATABITS-1:0]  rd_data,
    input  logic [ADDRBITS-1:0]           wr_addr,
    input  logic [DATABITS-1:0]           wr_data,
    input  logic [DATABITS/8-1:0]         wr_be,
    input  logic                          wr_req,
    output logic [NRDPORTS:0]             line_hit,
    input  logic                          line_flush,
    input  logic                          line_fill,
    input  logic [ADDRBITS-LSBBITS-1:0]   new_region,
    output logic                          line_ready,
    output logic                          line_dirty,
    output logic [TTLBITS-1:0]            line_ttl,
    output logic [ADDRBITS-1:0]           mem_addr,
    output logic [DATABITS-1:0]           mem_wdata,
    input  logic [DATABITS-1:0]           mem_rdata,
    input  logic                          mem_rvalid,
    output logic                          mem_rdreq,
    output logic                          mem_wrreq,
    input  logic                          mem_ready
`ifdef CACHE_LINE_STATS_EN
    ,
    output logic [31:0]                   stat_hits,
    output logic [31:0]                   stat_misses
`endif
);
    localparam int BYTES   = DATABITS / 8;
    localparam int WORDS   = (2 ** LSBBITS) / BYTES;
    localparam int WBITS   = $clog2(WORDS);
    localparam int BOFF    = $clog2(BYTES);
    localparam int TAGBITS = ADDRBITS - LSBBITS;
    localparam logic [TTLBITS-1:0] MAXTTL = '1;

    typedef enum logic [1:0] {S_EMPTY, S_CACHING, S_FLUSH, S_FILL} state_t;
    state_t state, state_nx;

    logic [TAGBITS-1:0]  tag, pend_tag;
    logic                pend_valid;
    logic [WORDS-1:0]    dirty;
    logic [DATABITS-1:0] words [WORDS];
    logic [WBITS-1:0]    fcnt, rcnt, bcnt, fcnt_inc, rcnt_inc, bcnt_inc;
    logic                req_done;
    logic [TTLBITS-1:0]  ttl;
    logic                wr_hit, any_hit, rd_acc, fill_beat;
    logic                flush_adv, flush_done, fill_done, latch_new, latch_pend;
    logic [WBITS-1:0]    wr_idx;
    logic [WBITS-1:0]    rd_idx [NRDPORTS];
    logic                unused_bits;

    assign wr_hit     = line_hit[NRDPORTS];
    assign any_hit    = |line_hit;
    assign wr_idx     = wr_addr[BOFF +: WBITS];
    assign fcnt_inc   = fcnt + 1'b1;
    assign rcnt_inc   = rcnt + 1'b1;
    assign bcnt_inc   = bcnt + 1'b1;
    assign rd_acc     = mem_rdreq && mem_ready;
    assign fill_beat  = (state == S_FILL) && mem_rvalid;
    assign line_ready = !reset && ((state == S_EMPTY) || (state == S_CACHING));
    assign line_dirty = |dirty;
    assign line_ttl   = ttl;

    // byte-offset address bits never select anything inside a word
    always_comb begin
        unused_bits = ^wr_addr[BOFF-1:0];
        for (int i = 0; i < NRDPORTS; i++)
            unused_bits = unused_bits ^ (^rd_addr[i*ADDRBITS +: BOFF]);
    end

    // tag compare per port, qualified by request and CACHING
    always_comb begin
        line_hit = '0;
        for (int i = 0; i < NRDPORTS; i++) begin
            rd_idx[i]   = rd_addr[i*ADDRBITS+BOFF +: WBITS];
            line_hit[i] = rd_req[i] && (state == S_CACHING) &&
                          (rd_addr[i*ADDRBITS+LSBBITS +: TAGBITS] == tag);
        end
        line_hit[NRDPORTS] = wr_req && (state == S_CACHING) &&
                             (wr_addr[ADDRBITS-1:LSBBITS] == tag);
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_EMPTY;
        else       state <= state_nx;
    end

    // next state and memory-side outputs
    always_comb begin
        state_nx   = state;
        mem_wrreq  = 1'b0;
        mem_rdreq  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        flush_adv  = 1'b0;
        flush_done = 1'b0;
        fill_done  = 1'b0;
        latch_new  = 1'b0;
        latch_pend = 1'b0;
        case (state)
            S_EMPTY: begin
                if (line_fill) begin
                    latch_new = 1'b1;
                    state_nx  = S_FILL;
                end
            end
            S_CACHING: begin
                // a write landing in this same cycle must also be flushed
                if (line_flush || line_fill) begin
                    if ((|dirty) || wr_hit) begin
                        latch_pend = 1'b1;
                        state_nx   = S_FLUSH;
                    end else if (line_fill) begin
                        latch_new = 1'b1;
                        state_nx  = S_FILL;
                    end else begin
                        state_nx = S_EMPTY;
                    end
                end
            end
            S_FLUSH: begin
                mem_addr = {tag, LSBBITS'(fcnt) << BOFF};
                if (dirty[fcnt]) begin
                    mem_wrreq = 1'b1;
                    mem_wdata = words[fcnt];
                    flush_adv = mem_ready;
                end else begin
                    flush_adv = 1'b1;
                end
                flush_done = flush_adv && (fcnt_inc == '0);
                if (flush_done) state_nx = pend_valid ? S_FILL : S_EMPTY;
            end
            S_FILL: begin
                mem_rdreq = !req_done;
                mem_addr  = {tag, LSBBITS'(rcnt) << BOFF};
                fill_done = fill_beat && (bcnt_inc == '0);
                if (fill_done) state_nx = S_CACHING;
            end
            default: state_nx = S_EMPTY;
        endcase
    end

    // tag, dirty mask, transfer counters, age and registered read ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag        <= '0;
            pend_tag   <= '0;
            pend_valid <= 1'b0;
            dirty      <= '0;
            fcnt       <= '0;
            rcnt       <= '0;
            bcnt       <= '0;
            req_done   <= 1'b0;
            ttl        <= MAXTTL;
            rd_valid   <= '0;
            rd_data    <= '0;
        end else begin
            if (latch_new)                      tag <= new_region;
            else if (flush_done && pend_valid)  tag <= pend_tag;
            if (latch_pend) begin
                pend_valid <= line_fill;
                pend_tag   <= new_region;
            end
            if (fill_done) begin
                dirty <= '0;
            end else begin
                if (wr_hit)                  dirty[wr_idx] <= 1'b1;
                if (flush_adv && mem_wrreq)  dirty[fcnt]   <= 1'b0;
            end
            if (flush_adv) fcnt <= fcnt_inc;
            if (rd_acc) begin
                rcnt <= rcnt_inc;
                if (rcnt_inc == '0) req_done <= 1'b1;
            end
            if (fill_done) req_done <= 1'b0;
            if (fill_beat) bcnt <= bcnt_inc;
            if (any_hit || fill_done)                    ttl <= MAXTTL;
            else if (state == S_CACHING && ttl != '0)    ttl <= ttl - 1'b1;
            for (int i = 0; i < NRDPORTS; i++) begin
                rd_valid[i] <= line_hit[i];
                if (line_hit[i]) rd_data[i*DATABITS +: DATABITS] <= words[rd_idx[i]];
            end
        end
    end

    // line storage: fill beats or byte-enabled write hits
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            words[bcnt] <= mem_rdata;
        end else if (wr_hit) begin
            for (int b = 0; b < BYTES; b++)
                if (wr_be[b]) words[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

`ifdef CACHE_LINE_STATS_EN
    // hit/miss event counters, wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (any_hit) begin
            stat_hits   <= stat_hits + 1'b1;
        end else if ((|rd_req) || wr_req) begin
            stat_misses <= stat_misses + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_line_mp.sv
// tb/tb_cache_line_mp.sv - randomized bench for cache_line_mp with a behavioural line model
module tb_cache_line_mp;
    localparam int AB = 32, DB = 32, LSB = 7, NR = 2, WORDS = 32;
    localparam int M_E = 0, M_C = 1, M_F = 2, M_L = 3;

    logic clk = 1'b0;
    logic reset;
    logic [NR*AB-1:0] rd_addr;
    logic [NR-1:0]    rd_req, rd_valid;
    logic [NR*DB-1:0] rd_data;
    logic [AB-1:0]    wr_addr;
    logic [DB-1:0]    wr_data;
    logic [3:0]       wr_be;
    logic             wr_req, line_flush, line_fill, line_ready, line_dirty;
    logic [NR:0]      line_hit;
    logic [AB-LSB-1:0] new_region;
    logic [7:0]       line_ttl;
    logic [AB-1:0]    mem_addr;
    logic [DB-1:0]    mem_wdata, mem_rdata;
    logic             mem_rvalid, mem_rdreq, mem_wrreq, mem_ready;
`ifdef CACHE_LINE_STATS_EN
    wire [31:0] stat_hits, stat_misses;
`endif

    cache_line_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_req(wr_req), .line_hit(line_hit), .line_flush(line_flush),
        .line_fill(line_fill), .new_region(new_region), .line_ready(line_ready),
        .line_dirty(line_dirty), .line_ttl(line_ttl), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq), .mem_ready(mem_ready)
`ifdef CACHE_LINE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, nprint = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (nprint < 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
            nprint++;
        end
    endtask

    // ---------------- behavioural line model ----------------
    int          m_mode, m_ttl, m_fidx, m_issued, m_beats;
    logic [24:0] m_tag, m_ptag;
    bit          m_pend;
    logic [31:0] m_data [WORDS];
    bit          m_dirty [WORDS];
    bit          m_rv [NR];
    logic [31:0] m_rd [NR];

    function automatic logic [31:0] word_addr(input logic [24:0] t, input int w);
        logic [4:0] w5 = w[4:0];
        return {t, w5, 2'b00};
    endfunction
    function automatic bit m_busy();
        return !(m_mode == M_E || m_mode == M_C);
    endfunction
    function automatic bit m_rd_hit(input int i);
        return rd_req[i] && m_mode == M_C && rd_addr[i*AB+LSB +: 25] == m_tag;
    endfunction
    function automatic bit m_wr_hit();
        return wr_req && m_mode == M_C && wr_addr[31:7] == m_tag;
    endfunction
    function automatic bit m_any_dirty();
        for (int w = 0; w < WORDS; w++) if (m_dirty[w]) return 1'b1;
        return 1'b0;
    endfunction
    function automatic bit exp_wrreq();
        return !reset && m_mode == M_F && m_dirty[m_fidx];
    endfunction
    function automatic bit exp_rdreq();
        return !reset && m_mode == M_L && m_issued < WORDS;
    endfunction

    task automatic model_reset();
        m_mode = M_E; m_tag = '0; m_ptag = '0; m_pend = 0; m_ttl = 255;
        m_fidx = 0; m_issued = 0; m_beats = 0;
        for (int w = 0; w < WORDS; w++) m_dirty[w] = 0;
        for (int i = 0; i < NR; i++) begin m_rv[i] = 0; m_rd[i] = '0; end
    endtask

    task automatic start_fill();
        m_mode = M_L; m_issued = 0; m_beats = 0;
    endtask

    task automatic model_step();
        bit h [NR];
        bit wh, anyhit, dirty_now, adv;
        int w;
        wh = m_wr_hit();
        anyhit = wh;
        for (int i = 0; i < NR; i++) begin h[i] = m_rd_hit(i); anyhit |= h[i]; end
        dirty_now = m_any_dirty() || wh;
        for (int i = 0; i < NR; i++) begin
            m_rv[i] = h[i];
            if (h[i]) m_rd[i] = m_data[rd_addr[i*AB+2 +: 5]];
        end
        if (wh) begin
            w = int'(wr_addr[6:2]);
            for (int b = 0; b < 4; b++) if (wr_be[b]) m_data[w][8*b +: 8] = wr_data[8*b +: 8];
            m_dirty[w] = 1;
        end
        if (anyhit) m_ttl = 255;
        else if (m_mode == M_C && m_ttl > 0) m_ttl--;
        case (m_mode)
            M_E: if (line_fill) begin m_tag = new_region; start_fill(); end
            M_C: if (line_flush || line_fill) begin
                if (dirty_now) begin
                    m_mode = M_F; m_pend = line_fill; m_ptag = new_region; m_fidx = 0;
                end else if (line_fill) begin
                    m_tag = new_region; start_fill();
                end else m_mode = M_E;
            end
            M_F: begin
                adv = 1;
                if (m_dirty[m_fidx]) begin
                    if (mem_ready) m_dirty[m_fidx] = 0; else adv = 0;
                end
                if (adv) begin
                    m_fidx++;
                    if (m_fidx == WORDS) begin
                        if (m_pend) begin m_tag = m_ptag; m_pend = 0; start_fill(); end
                        else m_mode = M_E;
                    end
                end
            end
            default: begin
                if (m_issued < WORDS && mem_ready) m_issued++;
                if (mem_rvalid) begin
                    m_data[m_beats] = mem_rdata;
                    m_beats++;
                    if (m_beats == WORDS) begin
                        m_mode = M_C; m_ttl = 255;
                        for (int k = 0; k < WORDS; k++) m_dirty[k] = 0;
                    end
                end
            end
        endcase
    endtask

    // ---------------- memory controller model ----------------
    logic [31:0] q_addr [$];
    logic [31:0] backing [logic [31:0]];
    int ready_pct = 100, rvalid_pct = 100, hold_n = 0;
    logic [31:0] hold_addr = '0;
    logic [31:0] rd_log [$];
    logic [31:0] wa_log [$];
    logic [31:0] wd_log [$];
    int held_9c = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return ((a >> 7) << 8) + ((a >> 2) & 32'd31);
    endfunction

    task automatic env_drive();
        mem_ready = ($urandom_range(99) < ready_pct);
        if (hold_n > 0 && exp_wrreq() && word_addr(m_tag, m_fidx) == hold_addr) begin
            mem_ready = 1'b0;
            hold_n--;
        end
        if (!reset && q_addr.size() > 0 && $urandom_range(99) < rvalid_pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_val(q_addr[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
    endtask

    // advance model and memory environment on each active edge
    always @(posedge clk) begin
        if (reset) begin
            model_reset();
            q_addr.delete();
        end else begin
            if (exp_rdreq() && mem_ready) q_addr.push_back(word_addr(m_tag, m_issued));
            if (exp_wrreq() && mem_ready) backing[word_addr(m_tag, m_fidx)] = m_data[m_fidx];
            if (mem_rvalid && q_addr.size() > 0) void'(q_addr.pop_front());
            model_step();
        end
    end

    // compare every output against the model away from the active edge
    always @(negedge clk) begin
        logic [NR:0]     eh;
        logic [NR-1:0]   erv;
        logic [NR*DB-1:0] erd;
        logic er, ed, ewr, erq;
        int et;
        if (reset) begin
            eh = '0; erv = '0; erd = '0; er = 0; ed = 0; et = 255; ewr = 0; erq = 0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                eh[i] = m_rd_hit(i);
                erv[i] = m_rv[i];
                erd[i*DB +: DB] = m_rd[i];
            end
            eh[NR] = m_wr_hit();
            er = !m_busy(); ed = m_any_dirty(); et = m_ttl;
            ewr = exp_wrreq(); erq = exp_rdreq();
        end
        check("line_hit", line_hit, eh);
        check("line_ready", line_ready, er);
        check("line_dirty", line_dirty, ed);
        check("line_ttl", line_ttl, et);
        check("rd_valid", rd_valid, erv);
        check("rd_data", rd_data, erd);
        check("mem_wrreq", mem_wrreq, ewr);
        check("mem_rdreq", mem_rdreq, erq);
        if (ewr && mem_wrreq) begin
            check("flush_addr", mem_addr, word_addr(m_tag, m_fidx));
            check("flush_data", mem_wdata, m_data[m_fidx]);
        end
        if (erq && mem_rdreq) check("fill_addr", mem_addr, word_addr(m_tag, m_issued));
        if (!reset && mem_rdreq && mem_ready) rd_log.push_back(mem_addr);
        if (!reset && mem_wrreq && mem_ready) begin wa_log.push_back(mem_addr); wd_log.push_back(mem_wdata); end
        if (!reset && mem_wrreq && mem_addr == 32'h9C) held_9c++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        rd_req = '0; wr_req = 0; line_flush = 0; line_fill = 0;
        env_drive();
    endtask

    task automatic clear_logs();
        rd_log.delete(); wa_log.delete(); wd_log.delete();
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        do begin tick(); n++; end while (m_busy() && n < budget);
        if (m_busy()) begin
            vectors++; miscompares++;
            $display("FAIL %s: line still busy after %0d cycles, required idle", name, n);
        end else check(name, line_ready, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [24:0] r;
        logic [4:0]  w;
        r = ($urandom_range(3) != 0) ? m_tag : 25'($urandom_range(7));
        w = 5'($urandom_range(31));
        return {r, w, 2'b00};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        model_reset();
        reset = 1; rd_addr = '0; rd_req = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        wr_req = 0; line_flush = 0; line_fill = 0; new_region = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ttl", line_ttl, 8'hFF);
        check("rst_ready", line_ready, 0);
        check("rst_valid", rd_valid, 0);
        reset = 0;

        // first fill of region 1
        tick(); clear_logs(); line_fill = 1; new_region = 25'h1;
        wait_ready("fill1_done", 200);
        check("fill1_reqs", rd_log.size(), 32);
        check("fill1_first", rd_log[0], 32'h80);
        check("fill1_last", rd_log[31], 32'hFC);
        check("fill1_ttl", line_ttl, 8'hFF);

        // single read
        tick(); rd_req = 2'b01; rd_addr[31:0] = 32'h88;
        tick();
        check("rd0_valid", rd_valid[0], 1);
        check("rd0_data", rd_data[31:0], 32'h102);

        // dual read, then port1 miss
        rd_req = 2'b11; rd_addr = {32'hFC, 32'h80};
        tick();
        check("dual_valid", rd_valid, 2'b11);
        check("dual_d0", rd_data[31:0], 32'h100);
        check("dual_d1", rd_data[63:32], 32'h11F);
        rd_req = 2'b11; rd_addr = {32'h200, 32'h80};
        #1;
        check("miss_hit1", line_hit[1], 0);
        tick();
        check("miss_valid", rd_valid, 2'b01);

        // byte-enabled write then flush of the single dirty word
        wr_req = 1; wr_addr = 32'h84; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        tick(); clear_logs(); line_flush = 1;
        wait_ready("flush1_done", 100);
        check("flush1_cnt", wa_log.size(), 1);
        check("flush1_addr", wa_log[0], 32'h84);
        check("flush1_data", wd_log[0], 32'h00BB01DD);
        check("flush1_dirty", line_dirty, 0);
        rd_req = 2'b01; rd_addr[31:0] = 32'h80;
        #1;
        check("empty_nohit", line_hit[0], 0);

        // flush+fill with two dirty words and backpressure on word 7
        tick(); line_fill = 1; new_region = 25'h1;
        wait_ready("fill2_done", 200);
        tick(); wr_req = 1; wr_addr = 32'h8C; wr_data = 32'h33333333; wr_be = 4'hF;
        tick(); wr_req = 1; wr_addr = 32'h9C; wr_data = 32'h77777777; wr_be = 4'hF;
        tick(); clear_logs(); held_9c = 0; hold_addr = 32'h9C; hold_n = 4;
        line_flush = 1; line_fill = 1; new_region = 25'h2;
        tick();
        check("ff_busy", line_ready, 0);
        wait_ready("ff_done", 300);
        check("ff_wcnt", wa_log.size(), 2);
        check("ff_w0", wa_log[0], 32'h8C);
        check("ff_w1", wa_log[1], 32'h9C);
        check("ff_d1", wd_log[1], 32'h77777777);
        check("ff_hold", held_9c, 5);
        check("ff_fill0", rd_log[0], 32'h100);
        tick(); rd_req = 2'b01; rd_addr[31:0] = 32'h104;
        tick();
        check("ff_rd", rd_data[31:0], 32'h201);

        // age saturation and reload
        repeat (300) tick();
        check("ttl_zero", line_ttl, 0);
        rd_req = 2'b01; rd_addr[31:0] = 32'h100;
        tick();
        check("ttl_reload", line_ttl, 8'hFF);

        // reset in the middle of a fill
        line_flush = 1; line_fill = 1; new_region = 25'h3;
        n = 0;
        do begin tick(); n++; end while (m_beats < 10 && n < 100);
        check("midfill_rdreq", mem_rdreq, 1);
        reset = 1;
        #1;
        check("rst_mid_rdreq", mem_rdreq, 0);
        check("rst_mid_ready", line_ready, 0);
        tick(); reset = 0;
        tick(); rd_req = 2'b01; rd_addr[31:0] = 32'h180;
        tick();
        check("rst_mid_read", rd_valid[0], 0);

        // randomized traffic
        ready_pct = 75; rvalid_pct = 70;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (!m_busy() && $urandom_range(29) == 0) begin
                int r = $urandom_range(2);
                line_flush = (r != 1);
                line_fill  = (r != 0);
                new_region = 25'($urandom_range(3));
            end
            if (m_mode == M_E && $urandom_range(9) == 0) begin
                line_fill = 1; new_region = 25'($urandom_range(3));
            end
            rd_req = 2'($urandom);
            for (int i = 0; i < NR; i++) rd_addr[i*AB +: AB] = rand_addr();
            wr_req = ($urandom_range(99) < 40);
            wr_addr = rand_addr(); wr_data = $urandom; wr_be = 4'($urandom);
        end
        wait_ready("rand_drain", 500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
